// File: rtl/minz_pkg.sv
// Shared types and constants for the minz response checker.
package minz_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int MINZ_N_IN = 4;
  localparam int N_VEC     = 2 ** MINZ_N_IN;

  // Truth table of the minimized 4-input function, vector index = {a,b,c,d}.
  localparam logic [N_VEC-1:0] MINZ_GOLDEN = 16'hA5F0;

endpackage

// File: rtl/minz_settle_cnt.sv
// Loadable down-counter; expired is high while the count sits at zero.
module minz_settle_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/minz_resp_checker.sv
// Sweeps all input vectors into minz, samples z after a settle time and scores it
// against EXPECTED. Optional first-failure capture: define MINZ_FIRST_FAIL_EN.
//
// state  | meaning
// IDLE   | waiting for start after reset
// DRIVE  | present idx on a..d, load settle counter
// SETTLE | hold a..d while the DUT output settles
// SAMPLE | capture z into resp, score against EXPECTED
// DONE   | results valid, waiting for restart
module minz_resp_checker
  import minz_pkg::*;
#(
  parameter int                      N_IN       = 4,
  parameter logic [(1<<N_IN)-1:0]    EXPECTED   = 16'h0000,
  parameter int                      SETTLE_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 z,
  output logic                 a,
  output logic                 b,
  output logic                 c,
  output logic                 d,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_cnt,
  output logic [(1<<N_IN)-1:0] resp
`ifdef MINZ_FIRST_FAIL_EN
  ,
  output logic                 first_fail_vld,
  output logic [N_IN-1:0]      first_fail_idx
`endif
);

  localparam int NV = 1 << N_IN;
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  // Counter holds SETTLE_CYC-1 after DRIVE so SETTLE lasts exactly SETTLE_CYC cycles.
  localparam logic [CW-1:0] SETTLE_LOAD = CW'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);

  state_t          state;
  logic [N_IN-1:0] idx;
  logic [N_IN-1:0] stim;
  logic            settle_done;
  logic            mismatch;
  logic            last_vec;
  logic            start_ok;

  minz_settle_cnt #(.W(CW)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_DRIVE),
    .load_val (SETTLE_LOAD),
    .en       (state == ST_SETTLE),
    .expired  (settle_done)
  );

  assign mismatch = (z != EXPECTED[idx]);
  assign last_vec = (idx == N_IN'(NV - 1));
  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      stim    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
      resp    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            err_cnt <= '0;
            resp    <= '0;
            idx     <= '0;
            done    <= 1'b0;
            pass    <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          stim  <= idx;
          state <= (SETTLE_CYC == 0) ? ST_SAMPLE : ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_done) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          resp[idx] <= z;
          if (mismatch) err_cnt <= err_cnt + 1'b1;
          if (last_vec) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt == '0) && !mismatch;
            state <= ST_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= ST_DRIVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign {a, b, c, d} = stim;

`ifdef MINZ_FIRST_FAIL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
    end else if (start_ok) begin
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
    end else if ((state == ST_SAMPLE) && mismatch && !first_fail_vld) begin
      first_fail_vld <= 1'b1;
      first_fail_idx <= idx;
    end
  end
`else
  // start_ok only feeds the first-failure capture.
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_minz_resp_checker.sv
// Randomized self-checking bench for minz_resp_checker (SETTLE_CYC=4 and SETTLE_CYC=0 instances).
module tb_minz_resp_checker;
  import minz_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start4, start0, sel;
  logic [15:0] z_table;

  logic        a4, b4, c4, d4, busy4, done4, pass4, z4;
  logic [4:0]  err4;
  logic [15:0] resp4;
  logic        a0, b0, c0, d0, busy0, done0, pass0, z0;
  logic [4:0]  err0;
  logic [15:0] resp0;
`ifdef MINZ_FIRST_FAIL_EN
  logic        ffv4, ffv0;
  logic [3:0]  ffi4, ffi0;
`endif

  assign z4 = z_table[{a4, b4, c4, d4}];
  assign z0 = z_table[{a0, b0, c0, d0}];

  minz_resp_checker #(.N_IN(4), .EXPECTED(MINZ_GOLDEN), .SETTLE_CYC(4)) dut (
    .clk(clk), .rst(rst), .start(start4), .z(z4),
    .a(a4), .b(b4), .c(c4), .d(d4),
    .busy(busy4), .done(done4), .pass(pass4), .err_cnt(err4), .resp(resp4)
`ifdef MINZ_FIRST_FAIL_EN
    , .first_fail_vld(ffv4), .first_fail_idx(ffi4)
`endif
  );

  minz_resp_checker #(.N_IN(4), .EXPECTED(MINZ_GOLDEN), .SETTLE_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .z(z0),
    .a(a0), .b(b0), .c(c0), .d(d0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .resp(resp0)
`ifdef MINZ_FIRST_FAIL_EN
    , .first_fail_vld(ffv0), .first_fail_idx(ffi0)
`endif
  );

  logic        done_m, busy_m, pass_m;
  logic [4:0]  err_m;
  logic [15:0] resp_m;
  logic [3:0]  vec_m;
  assign done_m = sel ? done0 : done4;
  assign busy_m = sel ? busy0 : busy4;
  assign pass_m = sel ? pass0 : pass4;
  assign err_m  = sel ? err0  : err4;
  assign resp_m = sel ? resp0 : resp4;
  assign vec_m  = sel ? {a0, b0, c0, d0} : {a4, b4, c4, d4};
`ifdef MINZ_FIRST_FAIL_EN
  logic       ffv_m;
  logic [3:0] ffi_m;
  assign ffv_m = sel ? ffv0 : ffv4;
  assign ffi_m = sel ? ffi0 : ffi4;
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a sweep reads back the table, scores popcount of differences, takes 16*(S+2) cycles.
  task automatic run_sweep(input logic s0, input logic [15:0] tbl, input int pulse_at);
    int cycles;
    int exp_cyc;
    int exp_err;
    sel     = s0;
    z_table = tbl;
    exp_err = $countones(tbl ^ MINZ_GOLDEN);
    exp_cyc = 16 * ((s0 ? 0 : 4) + 2);
    if (s0) start0 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start4 = 1'b0;
    check_val("start_busy", busy_m, 1'b1);
    check_val("start_clr_done", done_m, 1'b0);
    check_val("start_clr_err", err_m, 5'd0);
    check_val("start_clr_resp", resp_m, 16'h0);
    cycles = 0;
    while (!done_m && cycles < 1000) begin
      if (cycles == pulse_at) begin
        if (s0) start0 = 1'b1; else start4 = 1'b1;
      end else begin
        start0 = 1'b0; start4 = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start0 = 1'b0; start4 = 1'b0;
    check_val("done_seen", done_m, 1'b1);
    check_val("done_latency", cycles, exp_cyc);
    check_val("busy_end", busy_m, 1'b0);
    check_val("err_cnt", err_m, exp_err);
    check_val("pass", pass_m, exp_err == 0);
    check_val("resp", resp_m, tbl);
    check_val("vec_hold_f", vec_m, 4'hF);
`ifdef MINZ_FIRST_FAIL_EN
    begin
      int ff;
      ff = -1;
      for (int i = 15; i >= 0; i--) if (tbl[i] != MINZ_GOLDEN[i]) ff = i;
      check_val("ff_vld", ffv_m, ff >= 0);
      if (ff >= 0) check_val("ff_idx", ffi_m, ff);
    end
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check_val(tag, {a4, b4, c4, d4, busy4, done4, pass4, err4, resp4}, 32'h0);
    check_val(tag, {a0, b0, c0, d0, busy0, done0, pass0, err0, resp0}, 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start4 = 1'b0; start0 = 1'b0; sel = 1'b0; z_table = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst = 1'b0;
    @(posedge clk); #1;

    run_sweep(1'b0, MINZ_GOLDEN, -1);
    run_sweep(1'b0, MINZ_GOLDEN ^ 16'h0020, -1);
    run_sweep(1'b0, 16'h0000, -1);

    // Reset in SETTLE of vector 7: vector 7 occupies edges 43..48 after the start edge.
    sel = 1'b0; z_table = 16'h0000; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (44) @(posedge clk);
    #1;
    check_val("pre_reset_busy", busy4, 1'b1);
    check_val("pre_reset_err", err4, 5'd3);
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_sweep(1'b0, MINZ_GOLDEN, -1);

    run_sweep(1'b0, MINZ_GOLDEN, 20);
    run_sweep(1'b0, MINZ_GOLDEN ^ 16'h8001, -1);

    run_sweep(1'b1, MINZ_GOLDEN, -1);
    run_sweep(1'b1, 16'h0000, 5);

    for (int k = 0; k < 6; k++) begin
      logic        s;
      logic [15:0] t;
      s = 1'($urandom_range(0, 1));
      t = ($urandom_range(0, 2) == 0) ? MINZ_GOLDEN : 16'($urandom);
      run_sweep(s, t, s ? int'($urandom_range(1, 28)) : int'($urandom_range(1, 90)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
